// File: rtl/mont_pkg.sv
// Shared constants and FSM encoding for the Montgomery multiplier datapath
// (loader, multiplier and unloader).
package mont_pkg;

  localparam int MONT_INPUT_SIZE     = 1024;
  localparam int MONT_WORD_SIZE      = 64;
  localparam int MONT_NWORDS         = MONT_INPUT_SIZE / MONT_WORD_SIZE;
  localparam int MONT_TIMEOUT_CYCLES = 131071;

  typedef logic [1:0] state_t;

  localparam state_t ST_LOAD   = 2'd0;
  localparam state_t ST_STREAM = 2'd1;
  localparam state_t ST_WAIT   = 2'd2;
  localparam state_t ST_FIN    = 2'd3;

endpackage

// File: rtl/mont_word_buffer.sv
// Operand register file: x in the low half, y in the high half.
// One write port and an asynchronous read port.
module mont_word_buffer
  import mont_pkg::*;
#(
  parameter int WORD_SIZE = MONT_WORD_SIZE,
  parameter int DEPTH     = 2 * MONT_NWORDS,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic [WORD_SIZE-1:0] wdata,
  input  logic [AW-1:0]        raddr,
  output logic [WORD_SIZE-1:0] rdata
);

  logic [WORD_SIZE-1:0] mem [DEPTH];

  // Contents carry no reset; every entry is rewritten before it is streamed.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mont_operand_loader.sv
// Buffers x then y from a host stream, then feeds them to the Montgomery
// multiplier one word per cycle and watches for its done or a timeout.
module mont_operand_loader
  import mont_pkg::*;
#(
  parameter int INPUT_SIZE     = MONT_INPUT_SIZE,
  parameter int WORD_SIZE      = MONT_WORD_SIZE,
  parameter int TIMEOUT_CYCLES = MONT_TIMEOUT_CYCLES
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WORD_SIZE-1:0] in_word,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 mm_reset,
  output logic [WORD_SIZE-1:0] bus,
  input  logic                 mm_done,
  output logic                 busy,
  output logic                 op_done,
  output logic                 timeout
);

  localparam int NWORDS = INPUT_SIZE / WORD_SIZE;
  localparam int DEPTH  = 2 * NWORDS;
  localparam int AW     = $clog2(DEPTH);
  localparam int WD_W   = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [AW-1:0]   LAST_IDX = AW'(DEPTH - 1);
  localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);

  state_t            state_reg, state_next;
  logic [AW-1:0]     wcnt_reg, wcnt_next;
  logic [WD_W-1:0]   wd_reg, wd_next;
  logic              timeout_reg, timeout_next;
  logic              buf_we;
  logic [WORD_SIZE-1:0] buf_rdata;

  assign buf_we = in_valid && (state_reg == ST_LOAD);

  mont_word_buffer #(
    .WORD_SIZE (WORD_SIZE),
    .DEPTH     (DEPTH)
  ) u_buffer (
    .clk   (clk),
    .we    (buf_we),
    .waddr (wcnt_reg),
    .wdata (in_word),
    .raddr (wcnt_reg),
    .rdata (buf_rdata)
  );

  // wcnt is the write index in LOAD and the read index in STREAM.
  always_comb begin
    state_next   = state_reg;
    wcnt_next    = wcnt_reg;
    wd_next      = wd_reg;
    timeout_next = 1'b0;
    case (state_reg)
      ST_LOAD: begin
        if (in_valid) begin
          wcnt_next = wcnt_reg + 1'b1;
          if (wcnt_reg == LAST_IDX) begin
            state_next = ST_STREAM;
            wcnt_next  = '0;
          end
        end
      end
      ST_STREAM: begin
        wcnt_next = wcnt_reg + 1'b1;
        if (wcnt_reg == LAST_IDX) begin
          state_next = ST_WAIT;
          wcnt_next  = '0;
          wd_next    = '0;
        end
      end
      ST_WAIT: begin
        // A done on the final watchdog cycle still wins over the timeout.
        if (mm_done) begin
          state_next = ST_FIN;
          wd_next    = '0;
        end else if (wd_reg == WD_LAST) begin
          state_next   = ST_LOAD;
          wd_next      = '0;
          timeout_next = 1'b1;
        end else begin
          wd_next = wd_reg + 1'b1;
        end
      end
      ST_FIN: begin
        state_next = ST_LOAD;
      end
      default: begin
        state_next = ST_LOAD;
        wcnt_next  = '0;
        wd_next    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= ST_LOAD;
      wcnt_reg    <= '0;
      wd_reg      <= '0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      wcnt_reg    <= wcnt_next;
      wd_reg      <= wd_next;
      timeout_reg <= timeout_next;
    end
  end

  // Outputs decode registered state only, so reset clears them at once.
  assign in_ready = (state_reg == ST_LOAD);
  assign mm_reset = (state_reg == ST_LOAD);
  assign bus      = (state_reg == ST_STREAM) ? buf_rdata : '0;
  assign busy     = (state_reg == ST_STREAM) || (state_reg == ST_WAIT);
  assign op_done  = (state_reg == ST_FIN);
  assign timeout  = timeout_reg;

endmodule
